// File: rtl/eth_phy_10g_rx_lock_multi_pkg.sv
// Shared definitions for the multi-lane 64b/66b block-lock / BER monitor:
// sync-header codes, lane FSM state encoding and header classification.
package eth_phy_10g_rx_lock_multi_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Per-lane BER error counter is fixed at 7 bits and saturates at 127.
  localparam int         ERR_CNT_W   = 7;
  localparam logic [6:0] ERR_CNT_MAX = 7'd127;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_SLIP_HIGH = 2'd1,
    ST_SLIP_LOW  = 2'd2,
    ST_LOCKED    = 2'd3
  } lane_state_e;

  // A sync header is legal only when its two bits differ.
  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_lock_multi_if.sv
// Bundle of the per-lane SERDES header inputs, lane configuration and the
// lock / BER status outputs of the receive lock monitor.
interface eth_phy_10g_rx_lock_multi_if
  import eth_phy_10g_rx_lock_multi_pkg::*;
#(
  parameter int LANES = 4
);

  logic [2*LANES-1:0]         serdes_rx_hdr;
  logic [LANES-1:0]           serdes_rx_hdr_valid;
  logic [LANES-1:0]           cfg_lane_enable;
  logic [LANES-1:0]           serdes_rx_bitslip;
  logic [LANES-1:0]           rx_block_lock;
  logic [LANES-1:0]           rx_high_ber;
  logic [ERR_CNT_W*LANES-1:0] rx_error_count;
  logic                       rx_all_locked;

  // SERDES / configuration side.
  modport master (
    output serdes_rx_hdr,
    output serdes_rx_hdr_valid,
    output cfg_lane_enable,
    input  serdes_rx_bitslip,
    input  rx_block_lock,
    input  rx_high_ber,
    input  rx_error_count,
    input  rx_all_locked
  );

  // Lock monitor side.
  modport slave (
    input  serdes_rx_hdr,
    input  serdes_rx_hdr_valid,
    input  cfg_lane_enable,
    output serdes_rx_bitslip,
    output rx_block_lock,
    output rx_high_ber,
    output rx_error_count,
    output rx_all_locked
  );

endinterface

// File: rtl/eth_phy_10g_lane_lock.sv
// Single-lane 64b/66b sync-header lock FSM with timed bitslip, locked-state
// window monitoring and per-period invalid-header (BER) accumulation.
module eth_phy_10g_lane_lock
  import eth_phy_10g_rx_lock_multi_pkg::*;
#(
  parameter int LOCK_COUNT          = 64,
  parameter int WINDOW              = 64,
  parameter int BAD_LIMIT           = 16,
  parameter int BER_LIMIT           = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lane_enable,
  input  logic                 hdr_valid,
  input  logic [1:0]           hdr,
  input  logic                 ber_wrap,
  output logic                 bitslip,
  output logic                 block_lock,
  output logic                 high_ber,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W    = $clog2(WINDOW + 1);
  localparam int BAD_W    = $clog2(BAD_LIMIT + 1);
  localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int SLIP_W   = $clog2(SLIP_MAX + 1);
  // Threshold above the 7-bit counter range can never be reached.
  localparam int BER_LIM_SAT = (BER_LIMIT > 127) ? 128 : BER_LIMIT;

  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
  localparam logic [WIN_W-1:0]  WIN_TGT   = WIN_W'(WINDOW);
  localparam logic [BAD_W-1:0]  BAD_TGT   = BAD_W'(BAD_LIMIT);
  localparam logic [SLIP_W-1:0] SLIP_ONE  = SLIP_W'(1);
  localparam logic [SLIP_W-1:0] HIGH_LAST = SLIP_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [SLIP_W-1:0] LOW_LAST  =
    SLIP_W'((BITSLIP_LOW_CYCLES > 0) ? (BITSLIP_LOW_CYCLES - 1) : 0);
  localparam logic [7:0]        BER_TGT   = 8'(BER_LIM_SAT);

  lane_state_e          state_q, state_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [BAD_W-1:0]     bad_q, bad_d;
  logic [SLIP_W-1:0]    slip_q, slip_d;
  logic [ERR_CNT_W-1:0] ber_q, ber_d;
  logic                 bitslip_q, bitslip_d;
  logic                 lock_q, lock_d;
  logic                 high_ber_q, high_ber_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic                 hdr_ok_s;
  logic                 hdr_bad_s;
  logic                 ber_counting_s;
  logic [GOOD_W-1:0]    good_inc_s;
  logic [WIN_W-1:0]     win_inc_s;
  logic [BAD_W-1:0]     bad_inc_s;
  logic [ERR_CNT_W-1:0] ber_next_s;

  assign hdr_ok_s   = hdr_is_valid(hdr);
  assign hdr_bad_s  = hdr_valid & ~hdr_ok_s;
  assign good_inc_s = good_q + GOOD_ONE;
  assign win_inc_s  = win_q + WIN_ONE;
  assign bad_inc_s  = bad_q + BAD_W'(hdr_bad_s);

  // Invalid headers are not counted while a bitslip is in progress.
  assign ber_counting_s = hdr_bad_s &&
                          ((state_q == ST_UNLOCKED) || (state_q == ST_LOCKED));
  assign ber_next_s = (ber_counting_s && (ber_q != ERR_CNT_MAX)) ?
                      (ber_q + 7'd1) : ber_q;

  // Next-state logic: lock FSM, window counters, BER period accumulation.
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    win_d      = win_q;
    bad_d      = bad_q;
    slip_d     = slip_q;
    bitslip_d  = bitslip_q;
    lock_d     = lock_q;
    ber_d      = ber_q;
    high_ber_d = high_ber_q;
    err_d      = err_q;

    case (state_q)
      ST_UNLOCKED: begin
        if (hdr_valid) begin
          if (hdr_ok_s) begin
            if (good_inc_s == GOOD_TGT) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
              lock_d  = 1'b1;
            end else begin
              good_d = good_inc_s;
            end
          end else begin
            state_d   = ST_SLIP_HIGH;
            good_d    = '0;
            slip_d    = '0;
            bitslip_d = 1'b1;
          end
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_SLIP_HIGH: begin
        if (slip_q == HIGH_LAST) begin
          slip_d    = '0;
          bitslip_d = 1'b0;
          if (BITSLIP_LOW_CYCLES == 0) begin
            state_d = ST_UNLOCKED;
          end else begin
            state_d = ST_SLIP_LOW;
          end
        end else begin
          slip_d = slip_q + SLIP_ONE;
        end
      end
      ST_SLIP_LOW: begin
        if (slip_q == LOW_LAST) begin
          slip_d  = '0;
          state_d = ST_UNLOCKED;
        end else begin
          slip_d = slip_q + SLIP_ONE;
        end
      end
      ST_LOCKED: begin
        if (hdr_valid) begin
          // The current header is included before either limit is tested.
          if (bad_inc_s == BAD_TGT) begin
            state_d   = ST_SLIP_HIGH;
            lock_d    = 1'b0;
            bitslip_d = 1'b1;
            slip_d    = '0;
            win_d     = '0;
            bad_d     = '0;
          end else if (win_inc_s == WIN_TGT) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_inc_s;
            bad_d = bad_inc_s;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d   = ST_UNLOCKED;
        good_d    = '0;
        win_d     = '0;
        bad_d     = '0;
        slip_d    = '0;
        bitslip_d = 1'b0;
        lock_d    = 1'b0;
      end
    endcase

    // Period boundary: publish the finished period, including this cycle.
    if (ber_wrap) begin
      high_ber_d = ({1'b0, ber_next_s} >= BER_TGT);
      err_d      = ber_next_s;
      ber_d      = '0;
    end else begin
      ber_d = ber_next_s;
    end

    // A disabled lane is parked in its reset state with quiet outputs.
    if (!lane_enable) begin
      state_d    = ST_UNLOCKED;
      good_d     = '0;
      win_d      = '0;
      bad_d      = '0;
      slip_d     = '0;
      bitslip_d  = 1'b0;
      lock_d     = 1'b0;
      ber_d      = '0;
      high_ber_d = 1'b0;
      err_d      = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Lane state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      good_q     <= '0;
      win_q      <= '0;
      bad_q      <= '0;
      slip_q     <= '0;
      bitslip_q  <= 1'b0;
      lock_q     <= 1'b0;
      ber_q      <= '0;
      high_ber_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      win_q      <= win_d;
      bad_q      <= bad_d;
      slip_q     <= slip_d;
      bitslip_q  <= bitslip_d;
      lock_q     <= lock_d;
      ber_q      <= ber_d;
      high_ber_q <= high_ber_d;
      err_q      <= err_d;
    end
  end

  assign bitslip     = bitslip_q;
  assign block_lock  = lock_q;
  assign high_ber    = high_ber_q;
  assign error_count = err_q;

endmodule

// File: rtl/eth_phy_10g_rx_lock_multi.sv
// Multi-lane receive block-lock and BER monitor: one lock engine per lane,
// a shared 125 us period timer and the all-lanes-locked aggregate.
module eth_phy_10g_rx_lock_multi
  import eth_phy_10g_rx_lock_multi_pkg::*;
#(
  parameter int LANES               = 4,
  parameter int LOCK_COUNT          = 64,
  parameter int WINDOW              = 64,
  parameter int BAD_LIMIT           = 16,
  parameter int BER_LIMIT           = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531
) (
  input logic                        clk,
  input logic                        rst_n,
  eth_phy_10g_rx_lock_multi_if.slave bus
);

  localparam int             TMR_W    = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(COUNT_125US - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       wrap_s;
  logic                       all_locked_q, all_locked_d;
  logic [LANES-1:0]           bitslip_s;
  logic [LANES-1:0]           lock_s;
  logic [LANES-1:0]           high_ber_s;
  logic [ERR_CNT_W*LANES-1:0] err_cnt_s;

  // The wrap cycle is the last cycle of a period; lanes close it out then.
  assign wrap_s = (timer_q == TMR_LAST);

  // Free-running period timer, independent of lane state.
  always_comb begin
    if (wrap_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_ONE;
    end
  end

  // Locked-over-enabled-lanes aggregate; false when no lane is enabled.
  always_comb begin
    if (bus.cfg_lane_enable == '0) begin
      all_locked_d = 1'b0;
    end else begin
      all_locked_d = &(lock_s | ~bus.cfg_lane_enable);
    end
  end

  // Timer and aggregate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q      <= '0;
      all_locked_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      all_locked_q <= all_locked_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    eth_phy_10g_lane_lock #(
      .LOCK_COUNT          (LOCK_COUNT),
      .WINDOW              (WINDOW),
      .BAD_LIMIT           (BAD_LIMIT),
      .BER_LIMIT           (BER_LIMIT),
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .lane_enable (bus.cfg_lane_enable[i]),
      .hdr_valid   (bus.serdes_rx_hdr_valid[i]),
      .hdr         (bus.serdes_rx_hdr[2*i +: 2]),
      .ber_wrap    (wrap_s),
      .bitslip     (bitslip_s[i]),
      .block_lock  (lock_s[i]),
      .high_ber    (high_ber_s[i]),
      .error_count (err_cnt_s[ERR_CNT_W*i +: ERR_CNT_W])
    );
  end

  assign bus.serdes_rx_bitslip = bitslip_s;
  assign bus.rx_block_lock     = lock_s;
  assign bus.rx_high_ber       = high_ber_s;
  assign bus.rx_error_count    = err_cnt_s;
  assign bus.rx_all_locked     = all_locked_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_multi.sv
// Scoreboard bench for the multi-lane lock monitor. Stimulus drives random
// headers on the falling edge and pushes the reference model's expected
// outputs; a monitor pops one entry after each rising edge and compares.
module tb_eth_phy_10g_rx_lock_multi;

  localparam int LANES = 4;
  localparam int LOCKC = 64;
  localparam int WIN   = 64;
  localparam int BADL  = 16;
  localparam int BERL  = 16;
  localparam int SLIPH = 1;
  localparam int SLIPL = 8;
  localparam int CNT   = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_phy_10g_rx_lock_multi_if #(.LANES(LANES)) bus ();

  eth_phy_10g_rx_lock_multi #(
    .LANES(LANES), .LOCK_COUNT(LOCKC), .WINDOW(WIN), .BAD_LIMIT(BADL),
    .BER_LIMIT(BERL), .BITSLIP_HIGH_CYCLES(SLIPH),
    .BITSLIP_LOW_CYCLES(SLIPL), .COUNT_125US(CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  bs;
    logic [3:0]  lk;
    logic [3:0]  hb;
    logic [27:0] ec;
    logic        all;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: plain counters per lane; "slip_left" counts the
  // remaining cycles in which headers are ignored after a slip request.
  int   m_good[LANES], m_win[LANES], m_bad[LANES], m_slip[LANES];
  int   m_ber[LANES], m_ec[LANES];
  bit   m_lock[LANES], m_hb[LANES];
  bit   m_all;
  int   m_tick;

  // Stimulus knobs: invalid-header rate out of 64, forced bad run, pause rate.
  int         err_rate[LANES];
  int         force_bad[LANES];
  int         pause_rate;
  logic [3:0] en_cfg;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0; m_slip[l] = 0;
      m_ber[l] = 0; m_ec[l] = 0; m_lock[l] = 1'b0; m_hb[l] = 1'b0;
    end
    m_all  = 1'b0;
    m_tick = 0;
  endtask

  task automatic model_step(input logic [7:0] hdr, input logic [3:0] vld, input logic [3:0] en);
    exp_t       e;
    bit         wrap, all_n, take, bad;
    logic [1:0] h;
    all_n = (en != 4'd0);
    for (int l = 0; l < LANES; l++) if (en[l] && !m_lock[l]) all_n = 1'b0;
    wrap   = (m_tick == CNT - 1);
    m_tick = wrap ? 0 : m_tick + 1;
    for (int l = 0; l < LANES; l++) begin
      h = hdr[2*l +: 2];
      if (!en[l]) begin
        m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0; m_slip[l] = 0;
        m_ber[l] = 0; m_ec[l] = 0; m_lock[l] = 1'b0; m_hb[l] = 1'b0;
        continue;
      end
      take = vld[l] && (m_slip[l] == 0);
      bad  = take && ((h == 2'b00) || (h == 2'b11));
      if (m_slip[l] > 0) begin
        m_slip[l]--;
      end else if (take) begin
        if (!m_lock[l]) begin
          if (bad) begin
            m_good[l] = 0;
            m_slip[l] = SLIPH + SLIPL;
          end else begin
            m_good[l]++;
            if (m_good[l] == LOCKC) begin
              m_lock[l] = 1'b1; m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0;
            end
          end
        end else begin
          m_win[l]++;
          if (bad) m_bad[l]++;
          if (m_bad[l] == BADL) begin
            m_lock[l] = 1'b0; m_win[l] = 0; m_bad[l] = 0;
            m_slip[l] = SLIPH + SLIPL;
          end else if (m_win[l] == WIN) begin
            m_win[l] = 0; m_bad[l] = 0;
          end
        end
      end
      if (bad && (m_ber[l] < 127)) m_ber[l]++;
      if (wrap) begin
        m_hb[l]  = (m_ber[l] >= BERL);
        m_ec[l]  = m_ber[l];
        m_ber[l] = 0;
      end
    end
    m_all = all_n;
    e = '0;
    for (int l = 0; l < LANES; l++) begin
      e.bs[l]        = (m_slip[l] > SLIPL);
      e.lk[l]        = m_lock[l];
      e.hb[l]        = m_hb[l];
      e.ec[7*l +: 7] = 7'(m_ec[l]);
    end
    e.all = m_all;
    exp_q.push_back(e);
  endtask

  // Called on a falling edge: drive one cycle of inputs and predict outputs.
  task automatic drive_one();
    logic [7:0] hdr;
    logic [3:0] vld;
    cyc++;
    for (int l = 0; l < LANES; l++) begin
      if (force_bad[l] > 0) begin
        hdr[2*l +: 2] = 2'b11;
        force_bad[l]--;
      end else if ($urandom_range(0, 63) < err_rate[l]) begin
        hdr[2*l +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      end else begin
        hdr[2*l +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      end
      vld[l] = ((cyc % 33) != 0) && ($urandom_range(0, 63) >= pause_rate);
    end
    bus.serdes_rx_hdr       = hdr;
    bus.serdes_rx_hdr_valid = vld;
    bus.cfg_lane_enable     = en_cfg;
    model_step(hdr, vld, en_cfg);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_one();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " bitslip"}, 32'(bus.serdes_rx_bitslip), 32'd0);
    chk({tag, " lock"},    32'(bus.rx_block_lock),     32'd0);
    chk({tag, " high_ber"},32'(bus.rx_high_ber),       32'd0);
    chk({tag, " err_cnt"}, 32'(bus.rx_error_count),    32'd0);
    chk({tag, " all_lock"},32'(bus.rx_all_locked),     32'd0);
  endtask

  task automatic set_rates(input int r0, input int r1, input int r2, input int r3);
    err_rate[0] = r0; err_rate[1] = r1; err_rate[2] = r2; err_rate[3] = r3;
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bitslip",    32'(bus.serdes_rx_bitslip), 32'(e.bs));
        chk("block_lock", 32'(bus.rx_block_lock),     32'(e.lk));
        chk("high_ber",   32'(bus.rx_high_ber),       32'(e.hb));
        chk("error_count",32'(bus.rx_error_count),    32'(e.ec));
        chk("all_locked", 32'(bus.rx_all_locked),     32'(e.all));
      end
    end
  end

  initial begin : stimulus
    rst_n                   = 1'b0;
    bus.serdes_rx_hdr       = 8'd0;
    bus.serdes_rx_hdr_valid = 4'd0;
    bus.cfg_lane_enable     = 4'hF;
    en_cfg                  = 4'hF;
    pause_rate              = 0;
    for (int l = 0; l < LANES; l++) force_bad[l] = 0;
    set_rates(0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Clean lock on all lanes while lane 2 starts misaligned for a while.
    @(negedge clk);
    rst_n = 1'b1;
    force_bad[2] = 27;
    drive_one();
    run(159);

    // Random error rates: lane 2 sits near the window limit, lane 3 far above.
    pause_rate = 4;
    set_rates(3, 0, 14, 20);
    run(2200);

    // Disable lane 1 for a while, then re-enable and let it relock.
    pause_rate = 0;
    set_rates(0, 0, 0, 0);
    run(100);
    en_cfg = 4'b1101;
    run(40);
    en_cfg = 4'b0000;
    run(10);
    en_cfg = 4'hF;
    run(120);

    // Asynchronous reset in the middle of a locked window.
    run(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_one();

    // Burst of invalid headers on lane 0, then clean traffic across periods.
    run(150);
    force_bad[0] = 3;
    set_rates(6, 0, 0, 0);
    run(700);
    set_rates(0, 0, 0, 0);
    run(1300);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
